rv_latency_monitor: RTL and testbench

//   Synthesizable per-channel cycle-latency monitor: measures clocks from a start

---
 rtl/rv_latency_monitor_if.sv | 30 +++
 rtl/rv_latency_monitor.sv | 80 ++++++++
 tb/tb_rv_latency_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv_latency_monitor_if.sv
// rv_latency_monitor_if: event inputs and statistics outputs of the latency monitor
interface rv_latency_monitor_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int SUM_W  = 32
);
   logic                      clr;
   logic [NUM_CH-1:0]         start;
   logic [NUM_CH-1:0]         done;
   logic [NUM_CH-1:0]         busy;
   logic [NUM_CH-1:0]         lat_valid;
   logic [NUM_CH*CNT_W-1:0]   lat_last;
   logic [NUM_CH*CNT_W-1:0]   lat_min;
   logic [NUM_CH*CNT_W-1:0]   lat_max;
   logic [NUM_CH*SUM_W-1:0]   lat_sum;
   logic [NUM_CH*CNT_W-1:0]   txn_cnt;
   logic [NUM_CH-1:0]         err_orphan;
   logic [NUM_CH-1:0]         err_timeout;
   logic [NUM_CH-1:0]         err_sat;
   modport master (
      output clr, start, done,
      input  busy, lat_valid, lat_last, lat_min, lat_max, lat_sum, txn_cnt,
             err_orphan, err_timeout, err_sat
   );
   modport slave (
      input  clr, start, done,
      output busy, lat_valid, lat_last, lat_min, lat_max, lat_sum, txn_cnt,
             err_orphan, err_timeout, err_sat
   );
endinterface

// File: rtl/rv_latency_monitor.sv
// rv_latency_monitor: per-channel start-to-done cycle latency with saturating statistics
module rv_latency_monitor #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int SUM_W   = 32,
   parameter int TIMEOUT = 0
) (
   input logic clk,
   input logic reset,
   rv_latency_monitor_if.slave m
);
   typedef enum logic {IDLE, BUSY} state_t;
   for (genvar g = 0; g < NUM_CH; g++) begin : ch
      state_t           state;
      logic [CNT_W-1:0] cnt, last, mn, mx, txn, lat;
      logic [SUM_W-1:0] sum;
      logic [SUM_W:0]   sum_nxt;
      logic             valid, orphan, tmo, sat, rec, tmo_hit;
      always_comb begin
         rec     = m.done[g] && (state == BUSY || m.start[g]);
         lat     = state == BUSY ? cnt : '0;
         sum_nxt = {1'b0, sum} + (SUM_W+1)'(lat);
         tmo_hit = TIMEOUT != 0 && state == BUSY && !m.done[g] && cnt == CNT_W'(TIMEOUT);
      end
      always_ff @(posedge clk) begin
         if (reset || m.clr) begin
            state  <= IDLE;
            cnt    <= '0;
            valid  <= 1'b0;
            last   <= '0;
            mn     <= '1;
            mx     <= '0;
            sum    <= '0;
            txn    <= '0;
            orphan <= 1'b0;
            tmo    <= 1'b0;
            sat    <= 1'b0;
         end else begin
            valid <= rec;
            if (rec) begin
               last <= lat;
               mn   <= lat < mn ? lat : mn;
               mx   <= lat > mx ? lat : mx;
               sum  <= sum_nxt[SUM_W] ? '1 : sum_nxt[SUM_W-1:0];
               txn  <= &txn ? txn : txn + CNT_W'(1);
               if (sum_nxt[SUM_W] || &txn) sat <= 1'b1;
            end
            if (state == IDLE) begin
               if (m.done[g] && !m.start[g]) orphan <= 1'b1;
               if (m.start[g] && !m.done[g]) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(1);
               end
            end else if (m.done[g]) begin
               // done together with start closes one transaction and opens the next
               state <= m.start[g] ? BUSY : IDLE;
               cnt   <= m.start[g] ? CNT_W'(1) : '0;
            end else if (tmo_hit) begin
               state <= IDLE;
               cnt   <= '0;
               tmo   <= 1'b1;
            end else if (&cnt) begin
               sat <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
      assign m.busy[g]                      = state == BUSY;
      assign m.lat_valid[g]                 = valid;
      assign m.lat_last[g*CNT_W +: CNT_W]   = last;
      assign m.lat_min[g*CNT_W +: CNT_W]    = mn;
      assign m.lat_max[g*CNT_W +: CNT_W]    = mx;
      assign m.lat_sum[g*SUM_W +: SUM_W]    = sum;
      assign m.txn_cnt[g*CNT_W +: CNT_W]    = txn;
      assign m.err_orphan[g]                = orphan;
      assign m.err_timeout[g]               = tmo;
      assign m.err_sat[g]                   = sat;
   end
endmodule

// File: tb/tb_rv_latency_monitor.sv
// tb_rv_latency_monitor: directed checks of latency, statistics, timeout, saturation and clear
module tb_rv_latency_monitor;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   rv_latency_monitor_if #(.NUM_CH(4), .CNT_W(16), .SUM_W(32)) m0 ();
   rv_latency_monitor_if #(.NUM_CH(4), .CNT_W(16), .SUM_W(32)) m1 ();
   rv_latency_monitor_if #(.NUM_CH(4), .CNT_W(4),  .SUM_W(8))  m2 ();
   rv_latency_monitor #(.NUM_CH(4), .CNT_W(16), .SUM_W(32), .TIMEOUT(0))  d0 (.clk(clk), .reset(reset), .m(m0));
   rv_latency_monitor #(.NUM_CH(4), .CNT_W(16), .SUM_W(32), .TIMEOUT(20)) d1 (.clk(clk), .reset(reset), .m(m1));
   rv_latency_monitor #(.NUM_CH(4), .CNT_W(4),  .SUM_W(8),  .TIMEOUT(0))  d2 (.clk(clk), .reset(reset), .m(m2));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      {m0.clr, m0.start, m0.done} = '0;
      {m1.clr, m1.start, m1.done} = '0;
      {m2.clr, m2.start, m2.done} = '0;
      step(2);
      reset = 1'b0;
      check("rst_busy", 64'(m0.busy), 64'h0);
      check("rst_min", 64'(m0.lat_min), 64'hFFFF_FFFF_FFFF_FFFF);
      check("rst_max", 64'(m0.lat_max), 64'h0);
      check("rst_txn", 64'(m0.txn_cnt), 64'h0);
      check("rst_valid", 64'(m0.lat_valid), 64'h0);
      // single transaction on ch1, latency 7
      m0.start[1] = 1'b1; step(1); m0.start[1] = 1'b0;
      step(6);
      check("t1_busy", 64'(m0.busy[1]), 64'h1);
      m0.done[1] = 1'b1; step(1); m0.done[1] = 1'b0;
      check("t1_valid", 64'(m0.lat_valid[1]), 64'h1);
      check("t1_last", 64'(m0.lat_last[16 +: 16]), 64'd7);
      check("t1_min", 64'(m0.lat_min[16 +: 16]), 64'd7);
      check("t1_max", 64'(m0.lat_max[16 +: 16]), 64'd7);
      check("t1_sum", 64'(m0.lat_sum[32 +: 32]), 64'd7);
      check("t1_txn", 64'(m0.txn_cnt[16 +: 16]), 64'd1);
      check("t1_idle", 64'(m0.busy[1]), 64'h0);
      step(1);
      check("t1_pulse", 64'(m0.lat_valid[1]), 64'h0);
      // back-to-back on ch0: latencies 5 then 3
      m0.start[0] = 1'b1; step(1); m0.start[0] = 1'b0;
      step(4);
      m0.start[0] = 1'b1; m0.done[0] = 1'b1; step(1); m0.start[0] = 1'b0; m0.done[0] = 1'b0;
      check("t2_last5", 64'(m0.lat_last[0 +: 16]), 64'd5);
      check("t2_busy", 64'(m0.busy[0]), 64'h1);
      step(2);
      m0.done[0] = 1'b1; step(1); m0.done[0] = 1'b0;
      check("t2_last3", 64'(m0.lat_last[0 +: 16]), 64'd3);
      check("t2_min", 64'(m0.lat_min[0 +: 16]), 64'd3);
      check("t2_max", 64'(m0.lat_max[0 +: 16]), 64'd5);
      check("t2_sum", 64'(m0.lat_sum[0 +: 32]), 64'd8);
      check("t2_txn", 64'(m0.txn_cnt[0 +: 16]), 64'd2);
      check("t2_idle", 64'(m0.busy[0]), 64'h0);
      // ch2: simultaneous start&done in IDLE, then orphan done
      m0.start[2] = 1'b1; m0.done[2] = 1'b1; step(1); m0.start[2] = 1'b0; m0.done[2] = 1'b0;
      check("t3_valid", 64'(m0.lat_valid[2]), 64'h1);
      check("t3_last", 64'(m0.lat_last[32 +: 16]), 64'd0);
      check("t3_min", 64'(m0.lat_min[32 +: 16]), 64'd0);
      check("t3_txn", 64'(m0.txn_cnt[32 +: 16]), 64'd1);
      check("t3_busy", 64'(m0.busy[2]), 64'h0);
      m0.done[2] = 1'b1; step(1); m0.done[2] = 1'b0;
      check("t3_orphan", 64'(m0.err_orphan), 64'h4);
      check("t3_txn2", 64'(m0.txn_cnt[32 +: 16]), 64'd1);
      check("t3_novalid", 64'(m0.lat_valid[2]), 64'h0);
      // timeout after 20 cycles on d1 ch0
      m1.start[0] = 1'b1; step(1); m1.start[0] = 1'b0;
      step(19);
      check("t4_busy19", 64'(m1.busy[0]), 64'h1);
      step(1);
      check("t4_busy20", 64'(m1.busy[0]), 64'h0);
      check("t4_tmo", 64'(m1.err_timeout), 64'h1);
      check("t4_txn", 64'(m1.txn_cnt[0 +: 16]), 64'd0);
      check("t4_novalid", 64'(m1.lat_valid[0]), 64'h0);
      m1.done[0] = 1'b1; step(1); m1.done[0] = 1'b0;
      check("t4_orphan", 64'(m1.err_orphan), 64'h1);
      // CNT_W=4 saturation on d2 ch0, then clear mid-transaction with done
      m2.start[0] = 1'b1; step(1); m2.start[0] = 1'b0;
      step(19);
      check("t5_nosat_yet", 64'(m2.lat_last[0 +: 4]), 64'd0);
      m2.done[0] = 1'b1; step(1); m2.done[0] = 1'b0;
      check("t5_last", 64'(m2.lat_last[0 +: 4]), 64'd15);
      check("t5_sat", 64'(m2.err_sat), 64'h1);
      check("t5_txn", 64'(m2.txn_cnt[0 +: 4]), 64'd1);
      check("t5_sum", 64'(m2.lat_sum[0 +: 8]), 64'd15);
      m2.start[0] = 1'b1; step(1); m2.start[0] = 1'b0;
      step(3);
      m2.clr = 1'b1; m2.done[0] = 1'b1; step(1); m2.clr = 1'b0; m2.done[0] = 1'b0;
      check("t5_clr_busy", 64'(m2.busy), 64'h0);
      check("t5_clr_min", 64'(m2.lat_min), 64'hFFFF);
      check("t5_clr_last", 64'(m2.lat_last), 64'h0);
      check("t5_clr_txn", 64'(m2.txn_cnt), 64'h0);
      check("t5_clr_sat", 64'(m2.err_sat), 64'h0);
      check("t5_clr_valid", 64'(m2.lat_valid), 64'h0);
      step(1);
      check("t5_clr_valid2", 64'(m2.lat_valid), 64'h0);
      // staggered channels, reset mid-transaction
      for (int i = 0; i < 4; i++) begin
         m0.start[i] = 1'b1; step(1); m0.start[i] = 1'b0;
      end
      check("t6_busy", 64'(m0.busy), 64'hF);
      reset = 1'b1; step(1); reset = 1'b0;
      check("t6_busy_rst", 64'(m0.busy), 64'h0);
      check("t6_min", 64'(m0.lat_min), 64'hFFFF_FFFF_FFFF_FFFF);
      check("t6_max", 64'(m0.lat_max), 64'h0);
      check("t6_sum_lo", m0.lat_sum[63:0], 64'h0);
      check("t6_sum_hi", m0.lat_sum[127:64], 64'h0);
      check("t6_txn", 64'(m0.txn_cnt), 64'h0);
      check("t6_last", 64'(m0.lat_last), 64'h0);
      check("t6_orphan", 64'(m0.err_orphan), 64'h0);
      check("t6_tmo", 64'(m1.err_timeout), 64'h0);
      m0.start[3] = 1'b1; step(1); m0.start[3] = 1'b0;
      step(2);
      m0.done[3] = 1'b1; step(1); m0.done[3] = 1'b0;
      check("t6_last3", 64'(m0.lat_last[48 +: 16]), 64'd3);
      check("t6_txn3", 64'(m0.txn_cnt[48 +: 16]), 64'd1);
      check("t6_valid3", 64'(m0.lat_valid), 64'h8);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
